// File: rtl/fp_add_sequencer.sv
// fp_add_sequencer: multi-cycle IEEE-754 single add/sub controller driving a shared external 24-bit adder.
// Optional FP_ADD_SPECIAL_EN: NaN/inf classification in IDLE with a short bypass to DONE.
module fp_add_sequencer #(
  parameter int NORM_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        busy,
  output logic [23:0] add_a,
  output logic [23:0] add_b,
  output logic        add_ctl,
  output logic        add_en,
  input  logic [23:0] add_sum,
  input  logic        add_cout,
  input  logic [23:0] add_diff
);
  typedef enum logic [2:0] {IDLE, EXP, ALIGN, ADD, NORM, DONE, SPEC} state_t;
  state_t state, state_n;
  logic sx, sy, s, s_n, flush, special;
  logic [8:0] ex, ey, e, e_n;
  logic [23:0] mx, my, m, m_n, my_sh, m_add;
  logic [7:0] d;
  logic [2:0] lz, sh;
  logic [31:0] spec_v, spec_r, res_n;

  function automatic logic [23:0] mant(input logic [31:0] f);
    return |f[30:23] ? {1'b1, f[22:0]} : 24'b0;
  endfunction

  assign in_ready  = state == IDLE;
  assign busy      = !in_ready;
  assign out_valid = state == DONE;
  assign my_sh = d >= 8'd24 ? 24'b0 : my >> d;
  assign m_add = add_ctl ? add_diff : add_cout ? {1'b1, add_sum[23:1]} : add_sum;
  assign lz = m[23] ? 3'd0 : m[22] ? 3'd1 : m[21] ? 3'd2 : m[20] ? 3'd3 : 3'd4;
  assign sh = lz < 3'(NORM_STEP) ? lz : 3'(NORM_STEP);
  assign flush = e <= {6'b0, sh};
  assign res_n = state == SPEC ? spec_r :
                 e_n >= 9'd255 ? {s_n, 8'hFF, 23'b0} : {s_n, e_n[7:0], m_n[22:0]};

`ifdef FP_ADD_SPECIAL_EN
  logic nan_a, nan_b, inf_a, inf_b;
  assign nan_a = &in_a[30:23] && |in_a[22:0];
  assign nan_b = &in_b[30:23] && |in_b[22:0];
  assign inf_a = &in_a[30:23] && !(|in_a[22:0]);
  assign inf_b = &in_b[30:23] && !(|in_b[22:0]);
  assign special = &in_a[30:23] || &in_b[30:23];
  assign spec_v = (nan_a || nan_b || (inf_a && inf_b && (in_a[31] ^ in_b[31]))) ? 32'h7FC00000 :
                  inf_a ? in_a : in_b;
`else
  assign special = 1'b0;
  assign spec_v  = 32'b0;
`endif

  always_comb begin
    state_n = state;
    m_n = m;
    e_n = e;
    s_n = s;
    case (state)
      IDLE:  if (in_valid) state_n = special ? SPEC : EXP;
      EXP:   state_n = ALIGN;
      ALIGN: state_n = ADD;
      ADD: begin
        // an exact cancellation always yields +0
        m_n = m_add;
        e_n = m_add == 24'b0 ? 9'b0 : (!add_ctl && add_cout) ? ex + 9'd1 : ex;
        s_n = m_add != 24'b0 && (add_ctl && !add_cout ? sy : sx);
        state_n = (m_add == 24'b0 || m_add[23]) ? DONE : NORM;
      end
      NORM: begin
        m_n = flush ? 24'b0 : m << sh;
        e_n = flush ? 9'b0 : e - {6'b0, sh};
        state_n = (flush || m_n[23]) ? DONE : NORM;
      end
      DONE:    if (out_ready) state_n = IDLE;
      SPEC:    state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      {sx, sy, s} <= 3'b0;
      {ex, ey, e} <= 27'b0;
      {mx, my, m} <= 72'b0;
      d <= 8'b0;
      spec_r <= 32'b0;
      out_result <= 32'b0;
      add_a <= 24'b0;
      add_b <= 24'b0;
      add_ctl <= 1'b0;
      add_en <= 1'b0;
    end else begin
      state <= state_n;
      m <= m_n;
      e <= e_n;
      s <= s_n;
      add_en  <= state_n == EXP || state_n == ADD;
      add_ctl <= state_n == EXP || (state_n == ADD && (sx ^ sy));
      add_a <= state_n == EXP ? {16'b0, in_a[30:23]} : state_n == ADD ? mx : 24'b0;
      add_b <= state_n == EXP ? {16'b0, in_b[30:23]} : state_n == ADD ? my_sh : 24'b0;
      if (state == IDLE && in_valid) begin
        {sx, ex, mx} <= {in_a[31], 1'b0, in_a[30:23], mant(in_a)};
        {sy, ey, my} <= {in_b[31], 1'b0, in_b[30:23], mant(in_b)};
        spec_r <= spec_v;
      end
      // keep the larger-exponent operand in the X slot
      if (state == EXP) begin
        d <= add_diff[7:0];
        if (!add_cout) begin
          {sx, ex, mx} <= {sy, ey, my};
          {sy, ey, my} <= {sx, ex, mx};
        end
      end
      if (state_n == DONE && state != DONE) out_result <= res_n;
    end
  end
endmodule

// File: tb/tb_fp_add_sequencer.sv
// tb_fp_add_sequencer: random and directed checks of fp_add_sequencer against an arithmetic reference model.
module tb_fp_add_sequencer;
  localparam int STEP = 1;
  typedef struct {logic [31:0] r; int lat; int en;} exp_t;

  logic clk = 0, rst_n = 1, in_valid = 0, out_ready = 1, rand_rdy = 0;
  logic in_ready, out_valid, busy, add_ctl, add_en, add_cout;
  logic [31:0] in_a = 0, in_b = 0, out_result;
  logic [23:0] add_a, add_b, add_sum, add_diff;
  logic [24:0] full;
  exp_t q[$];
  int cyc = 0, en_cnt = 0, passes = 0, total = 0;
  logic seen = 0;

  fp_add_sequencer #(.NORM_STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .busy(busy), .add_a(add_a), .add_b(add_b),
    .add_ctl(add_ctl), .add_en(add_en), .add_sum(add_sum), .add_cout(add_cout),
    .add_diff(add_diff)
  );

  always #5 clk = ~clk;

  // external shared adder: carry out of A-B is the A>=B flag
  assign full = add_en ? ({1'b0, add_a} + {1'b0, add_ctl ? ~add_b : add_b} + 25'(add_ctl)) : 25'b0;
  assign add_sum  = full[23:0];
  assign add_cout = full[24];
  assign add_diff = !add_en ? 24'b0 : add_a >= add_b ? add_a - add_b : add_b - add_a;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b, output exp_t x);
    int ea = int'(a[30:23]), eb = int'(b[30:23]), ex, ey, e, d, lz;
    longint mx, my, m;
    bit sx, sy, s;
    x.r = 0; x.lat = 4; x.en = 2;
`ifdef FP_ADD_SPECIAL_EN
    if (ea == 255 || eb == 255) begin
      x.lat = 2; x.en = 0;
      x.r = ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) ||
             (ea == 255 && eb == 255 && a[31] != b[31])) ? 32'h7FC00000 : (ea == 255 ? a : b);
      return;
    end
`endif
    if (ea >= eb) begin
      sx = a[31]; ex = ea; mx = ea == 0 ? 0 : longint'({1'b1, a[22:0]});
      sy = b[31]; ey = eb; my = eb == 0 ? 0 : longint'({1'b1, b[22:0]});
    end else begin
      sx = b[31]; ex = eb; mx = eb == 0 ? 0 : longint'({1'b1, b[22:0]});
      sy = a[31]; ey = ea; my = ea == 0 ? 0 : longint'({1'b1, a[22:0]});
    end
    d = ex - ey;
    my = d >= 24 ? 0 : my >> d;
    e = ex;
    if (sx == sy) begin
      m = mx + my; s = sx;
      if (m >= (64'd1 << 24)) begin m = m >> 1; e = e + 1; end
    end else if (mx >= my) begin m = mx - my; s = sx; end
    else begin m = my - mx; s = sy; end
    if (m == 0) return;
    lz = 0;
    while (((m << lz) & 64'h800000) == 0) lz++;
    if (e <= lz) begin x.r = {s, 31'b0}; x.lat = -1; return; end
    m = m << lz; e = e - lz;
    x.lat = 4 + (lz + STEP - 1) / STEP;
    x.r = e >= 255 ? {s, 8'hFF, 23'b0} : {s, 8'(e), 23'(m)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    exp_t x;
    if (!rst_n) begin
      q.delete(); cyc <= 0; en_cnt <= 0;
    end else begin
      cyc <= cyc + 1;
      en_cnt <= en_cnt + int'(add_en);
      if (in_valid && in_ready) begin
        model(in_a, in_b, x);
        q.push_back(x);
        cyc <= 1; en_cnt <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) seen <= 0;
    else begin
      chk("ready_vs_busy", in_ready, !busy);
      if (out_valid) begin
        if (q.size() == 0) chk("unexpected_valid", out_valid, 0);
        else begin
          chk("result", out_result, q[0].r);
          if (!seen) begin
            if (q[0].lat >= 0) chk("latency", cyc, q[0].lat);
            chk("add_en_cycles", en_cnt, q[0].en);
          end
          seen <= !out_ready;
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = $urandom_range(0, 2) != 0;
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    @(posedge clk); #1;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin chk("send_in_ready", in_ready, 1); return; end
    in_valid = 1; in_a = a; in_b = b;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || !in_ready) && n < 200) begin @(posedge clk); #1; n++; end
    chk("drain", 32'(q.size() == 0 && in_ready), 1);
  endtask

  function automatic logic [31:0] rnd_fp(input int er);
    int k = int'($urandom_range(0, 11)), e;
    e = k == 0 ? 0 : k == 1 ? int'($urandom_range(1, 3)) : k == 2 ? 255 : k == 3 ? 254 :
        k <= 8 ? er + int'($urandom_range(0, 6)) - 3 : int'($urandom_range(1, 254));
    if (e < 0) e = 0;
    if (e > 255) e = 255;
    return {1'($urandom_range(0, 1)), 8'(e), 23'($urandom)};
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, total);
    $fatal(1);
  end

  initial begin
    exp_t x;
    logic [31:0] a, b;
    int n;
    #2 rst_n = 0;
    #10;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_add_bus", {add_a[15:0], add_b[13:0], add_ctl, add_en}, 0);
    @(posedge clk); #1 rst_n = 1;

    model(32'h3F800000, 32'h3F800000, x); chk("model_c1", x.r, 32'h40000000); chk("model_c1_lat", x.lat, 4);
    model(32'h3FC00000, 32'hBFC00000, x); chk("model_c2", x.r, 32'h00000000); chk("model_c2_lat", x.lat, 4);
    model(32'h3F800000, 32'hBF400000, x); chk("model_c3", x.r, 32'h3E800000); chk("model_c3_lat", x.lat, 6);
    model(32'h4B800000, 32'h3F800000, x); chk("model_c4", x.r, 32'h4B800000);
    model(32'h3F800000, 32'h4B800000, x); chk("model_c4_swap", x.r, 32'h4B800000);

    send(32'h3F800000, 32'h3F800000); wait_idle();
    send(32'h3FC00000, 32'hBFC00000); wait_idle();
    send(32'h3F800000, 32'hBF400000); wait_idle();
    send(32'h4B800000, 32'h3F800000); wait_idle();
    send(32'h3F800000, 32'h4B800000); wait_idle();

    // backpressure: result held, new operands ignored, then a back-to-back pair
    out_ready = 0;
    send(32'h3F800000, 32'h3F800000);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk("bp_valid", out_valid, 1);
    repeat (3) begin
      @(posedge clk); #1;
      in_valid = 1; in_a = 32'h40400000; in_b = 32'h3F800000;
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold", out_result, 32'h40000000);
    end
    @(posedge clk); #1 out_ready = 1;
    @(posedge clk); #1;
    chk("bp_idle", in_ready, 1);
    chk("bp_valid_drop", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 0;
    chk("bp_accept", busy, 1);
    send(32'hC0000000, 32'h3F000000);
    wait_idle();

    // asynchronous reset in the middle of normalisation
    send(32'h3F800000, 32'hBF400000);
    repeat (3) @(posedge clk);
    #2;
    chk("mid_busy", busy, 1);
    rst_n = 0;
    #1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_busy_clr", busy, 0);
    chk("mid_in_ready", in_ready, 1);
    chk("mid_add_en", add_en, 0);
    @(posedge clk); #1 rst_n = 1;
    send(32'h3F800000, 32'h3F800000); wait_idle();

`ifdef FP_ADD_SPECIAL_EN
    model(32'h7F800000, 32'hFF800000, x); chk("model_c7", x.r, 32'h7FC00000); chk("model_c7_lat", x.lat, 2);
    send(32'h7F800000, 32'hFF800000); wait_idle();
    send(32'h7F800000, 32'h3F800000); wait_idle();
`endif

    rand_rdy = 1;
    for (int i = 0; i < 400; i++) begin
      n = int'($urandom_range(1, 254));
      a = rnd_fp(n);
      b = rnd_fp(n);
      if ($urandom_range(0, 4) == 0) b = {~a[31], a[30:23], a[22:0] ^ 23'($urandom_range(0, 255))};
      send(a, b);
    end
    wait_idle();
    rand_rdy = 0;
    out_ready = 1;

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
